// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between the instruction-fetch unit (IFU) and the
// load/store unit (LSU). One transaction is outstanding at a time. Requests are arbitrated
// round-robin in IDLE. The accepted request is registered and presented to memory. The
// memory response is registered and routed back to the requester that owns the transaction.
//
// Ports
//   clk, rst                          clock (rising edge), asynchronous active-low reset
//   ifu_req_* / ifu_resp_*            IFU read request (valid/ready) and response pulse
//   lsu_req_* / lsu_resp_*            LSU load/store request and response pulse
//                                     (stores pulse with data 0)
//   mem_req_* / mem_resp_*            memory request (held until ready) and response pulse
//   busy                              high whenever a transaction is in flight
module mem_arbiter #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst,

  input  logic                    ifu_req_valid,
  input  logic [ADDR_WIDTH-1:0]   ifu_req_addr,
  output logic                    ifu_req_ready,
  output logic                    ifu_resp_valid,
  output logic [DATA_WIDTH-1:0]   ifu_resp_data,

  input  logic                    lsu_req_valid,
  input  logic [ADDR_WIDTH-1:0]   lsu_req_addr,
  input  logic                    lsu_req_wen,
  input  logic [DATA_WIDTH-1:0]   lsu_req_wdata,
  input  logic [DATA_WIDTH/8-1:0] lsu_req_wmask,
  output logic                    lsu_req_ready,
  output logic                    lsu_resp_valid,
  output logic [DATA_WIDTH-1:0]   lsu_resp_data,

  output logic                    mem_req_valid,
  output logic [ADDR_WIDTH-1:0]   mem_req_addr,
  output logic                    mem_req_wen,
  output logic [DATA_WIDTH-1:0]   mem_req_wdata,
  output logic [DATA_WIDTH/8-1:0] mem_req_wmask,
  input  logic                    mem_req_ready,
  input  logic                    mem_resp_valid,
  input  logic [DATA_WIDTH-1:0]   mem_resp_data,

  output logic                    busy
);

  localparam int unsigned MaskWidth = DATA_WIDTH / 8;

  typedef enum logic [1:0] {StIdle, StReq, StResp} state_e;

  state_e                  state_q, state_d;
  logic                    last_lsu_q, last_lsu_d;    // 1: LSU won the last grant
  logic                    owner_lsu_q, owner_lsu_d;  // 1: LSU owns the open transaction
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic                    wen_q, wen_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [MaskWidth-1:0]    wmask_q, wmask_d;
  logic                    ifu_resp_valid_q, ifu_resp_valid_d;
  logic [DATA_WIDTH-1:0]   ifu_resp_data_q, ifu_resp_data_d;
  logic                    lsu_resp_valid_q, lsu_resp_valid_d;
  logic [DATA_WIDTH-1:0]   lsu_resp_data_q, lsu_resp_data_d;

  logic grant_ifu, grant_lsu;

  // Round-robin arbitration. Readies are gated by rst so nothing is accepted in reset.
  always_comb begin
    grant_ifu = 1'b0;
    grant_lsu = 1'b0;
    if (rst && (state_q == StIdle)) begin
      if (ifu_req_valid && lsu_req_valid) begin
        grant_lsu = ~last_lsu_q;
        grant_ifu = last_lsu_q;
      end else begin
        grant_ifu = ifu_req_valid;
        grant_lsu = lsu_req_valid;
      end
    end
  end

  always_comb begin
    state_d          = state_q;
    last_lsu_d       = last_lsu_q;
    owner_lsu_d      = owner_lsu_q;
    addr_d           = addr_q;
    wen_d            = wen_q;
    wdata_d          = wdata_q;
    wmask_d          = wmask_q;
    ifu_resp_valid_d = 1'b0;
    ifu_resp_data_d  = ifu_resp_data_q;
    lsu_resp_valid_d = 1'b0;
    lsu_resp_data_d  = lsu_resp_data_q;

    unique case (state_q)
      StIdle: begin
        if (grant_ifu || grant_lsu) begin
          state_d     = StReq;
          owner_lsu_d = grant_lsu;
          last_lsu_d  = grant_lsu;
          addr_d      = grant_lsu ? lsu_req_addr : ifu_req_addr;
          wen_d       = grant_lsu & lsu_req_wen;
          wdata_d     = grant_lsu ? lsu_req_wdata : '0;
          // Byte mask only carries meaning for stores.
          wmask_d     = (grant_lsu && lsu_req_wen) ? lsu_req_wmask : '0;
        end
      end
      StReq: begin
        if (mem_req_ready) state_d = StResp;
      end
      StResp: begin
        if (mem_resp_valid) begin
          state_d = StIdle;
          if (owner_lsu_q) begin
            lsu_resp_valid_d = 1'b1;
            lsu_resp_data_d  = wen_q ? '0 : mem_resp_data;
          end else begin
            ifu_resp_valid_d = 1'b1;
            ifu_resp_data_d  = mem_resp_data;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q          <= StIdle;
      last_lsu_q       <= 1'b0;
      owner_lsu_q      <= 1'b0;
      addr_q           <= '0;
      wen_q            <= 1'b0;
      wdata_q          <= '0;
      wmask_q          <= '0;
      ifu_resp_valid_q <= 1'b0;
      ifu_resp_data_q  <= '0;
      lsu_resp_valid_q <= 1'b0;
      lsu_resp_data_q  <= '0;
    end else begin
      state_q          <= state_d;
      last_lsu_q       <= last_lsu_d;
      owner_lsu_q      <= owner_lsu_d;
      addr_q           <= addr_d;
      wen_q            <= wen_d;
      wdata_q          <= wdata_d;
      wmask_q          <= wmask_d;
      ifu_resp_valid_q <= ifu_resp_valid_d;
      ifu_resp_data_q  <= ifu_resp_data_d;
      lsu_resp_valid_q <= lsu_resp_valid_d;
      lsu_resp_data_q  <= lsu_resp_data_d;
    end
  end

  assign ifu_req_ready  = grant_ifu;
  assign lsu_req_ready  = grant_lsu;
  assign ifu_resp_valid = ifu_resp_valid_q;
  assign ifu_resp_data  = ifu_resp_data_q;
  assign lsu_resp_valid = lsu_resp_valid_q;
  assign lsu_resp_data  = lsu_resp_data_q;
  assign mem_req_valid  = (state_q == StReq);
  assign mem_req_addr   = addr_q;
  assign mem_req_wen    = wen_q;
  assign mem_req_wdata  = wdata_q;
  assign mem_req_wmask  = wmask_q;
  assign busy           = (state_q != StIdle);

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter. The stimulus driver predicts grants from the
// round-robin rule and queues the expected memory requests. A memory model pops and checks
// them, then queues the expected responses. A monitor pops and checks every response pulse.
module tb_mem_arbiter;

  typedef struct packed {
    logic        lsu;
    logic [31:0] addr;
    logic        wen;
    logic [31:0] wdata;
    logic [3:0]  wmask;
  } req_t;

  typedef struct packed {
    logic        lsu;
    logic [31:0] data;
  } resp_t;

  logic        clk, rst;
  logic        ifu_req_valid, ifu_req_ready, ifu_resp_valid;
  logic [31:0] ifu_req_addr, ifu_resp_data;
  logic        lsu_req_valid, lsu_req_wen, lsu_req_ready, lsu_resp_valid;
  logic [31:0] lsu_req_addr, lsu_req_wdata, lsu_resp_data;
  logic [3:0]  lsu_req_wmask;
  logic        mem_req_valid, mem_req_wen, mem_req_ready, mem_resp_valid;
  logic [31:0] mem_req_addr, mem_req_wdata, mem_resp_data;
  logic [3:0]  mem_req_wmask;
  logic        busy;

  int    checks = 0;
  int    errors = 0;
  req_t  exp_req_q[$];
  resp_t exp_resp_q[$];
  bit    grant_log[$];
  bit    ifu_pend, lsu_pend, txn_open, last_lsu, real_resp_fire;
  bit    use_fixed;
  int    fix_stall, fix_delay;
  logic [31:0] fix_data;

  mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .ifu_req_valid(ifu_req_valid), .ifu_req_addr(ifu_req_addr), .ifu_req_ready(ifu_req_ready),
    .ifu_resp_valid(ifu_resp_valid), .ifu_resp_data(ifu_resp_data),
    .lsu_req_valid(lsu_req_valid), .lsu_req_addr(lsu_req_addr), .lsu_req_wen(lsu_req_wen),
    .lsu_req_wdata(lsu_req_wdata), .lsu_req_wmask(lsu_req_wmask), .lsu_req_ready(lsu_req_ready),
    .lsu_resp_valid(lsu_resp_valid), .lsu_resp_data(lsu_resp_data),
    .mem_req_valid(mem_req_valid), .mem_req_addr(mem_req_addr), .mem_req_wen(mem_req_wen),
    .mem_req_wdata(mem_req_wdata), .mem_req_wmask(mem_req_wmask),
    .mem_req_ready(mem_req_ready), .mem_resp_valid(mem_resp_valid),
    .mem_resp_data(mem_resp_data), .busy(busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic raise_ifu(input logic [31:0] a);
    ifu_req_addr = a;
    ifu_pend     = 1'b1;
  endtask

  task automatic raise_lsu(input logic [31:0] a, input bit w, input logic [31:0] d,
                           input logic [3:0] m);
    lsu_req_addr  = a;
    lsu_req_wen   = w;
    lsu_req_wdata = d;
    lsu_req_wmask = m;
    lsu_pend      = 1'b1;
  endtask

  // One clock of driving: entered and left at posedge+1.
  task automatic step();
    bit ei, el;
    ifu_req_valid = ifu_pend;
    lsu_req_valid = lsu_pend;
    @(negedge clk);
    #2;
    // Grant only when idle; on contention the requester that did not win last time wins.
    ei = !txn_open && ifu_pend && (!lsu_pend || last_lsu);
    el = !txn_open && lsu_pend && (!ifu_pend || !last_lsu);
    chk("ifu_req_ready", ifu_req_ready, ei);
    chk("lsu_req_ready", lsu_req_ready, el);
    chk("busy", busy, txn_open);
    if (lsu_req_valid && lsu_req_ready) grant_log.push_back(1'b1);
    else if (ifu_req_valid && ifu_req_ready) grant_log.push_back(1'b0);
    if (el) begin
      exp_req_q.push_back(req_t'{1'b1, lsu_req_addr, lsu_req_wen, lsu_req_wdata,
                                 lsu_req_wmask});
      lsu_pend = 1'b0;
      last_lsu = 1'b1;
      txn_open = 1'b1;
    end else if (ei) begin
      exp_req_q.push_back(req_t'{1'b0, ifu_req_addr, 1'b0, 32'h0, 4'h0});
      ifu_pend = 1'b0;
      last_lsu = 1'b0;
      txn_open = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    for (int k = 0; k < 300 && (ifu_pend || lsu_pend || txn_open); k++) step();
    chk("drain_done", {ifu_pend, lsu_pend, txn_open}, 3'b000);
  endtask

  // Memory model: checks each request, stalls, then returns one response.
  initial begin
    int          mstate, stall, delay;
    req_t        cur;
    logic [31:0] d;
    mstate = 0; stall = 0; delay = 0; cur = '0;
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_data = 32'h0; real_resp_fire = 1'b0;
    forever begin
      @(negedge clk);
      mem_resp_valid = 1'b0;
      real_resp_fire = 1'b0;
      if (!rst) begin
        mstate        = 0;
        mem_req_ready = 1'b0;
      end else begin
        case (mstate)
          0: begin
            if (mem_req_valid) begin
              if (exp_req_q.size() == 0) begin
                chk("mem_req_unexpected", mem_req_valid, 1'b0);
              end else begin
                cur = exp_req_q.pop_front();
                chk("mem_req_addr", mem_req_addr, cur.addr);
                chk("mem_req_wen", mem_req_wen, cur.wen);
                chk("mem_req_wmask", mem_req_wmask, cur.wen ? cur.wmask : 4'h0);
                if (cur.wen) chk("mem_req_wdata", mem_req_wdata, cur.wdata);
                stall = use_fixed ? fix_stall : $urandom_range(0, 3);
                delay = use_fixed ? fix_delay : $urandom_range(0, 2);
                if (stall == 0) begin
                  mem_req_ready = 1'b1;
                  mstate        = 2;
                end else begin
                  mem_req_ready = 1'b0;
                  mstate        = 1;
                end
              end
            end else if ($urandom_range(0, 5) == 0) begin
              // Stray response while idle: must be ignored.
              mem_resp_valid = 1'b1;
              mem_resp_data  = $urandom;
            end
          end
          1: begin
            chk("mem_req_hold", {mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wmask},
                {1'b1, cur.addr, cur.wen, cur.wen ? cur.wmask : 4'h0});
            if (cur.wen) chk("mem_req_hold_wdata", mem_req_wdata, cur.wdata);
            stall--;
            if (stall == 0) begin
              mem_req_ready = 1'b1;
              mstate        = 2;
            end else if ($urandom_range(0, 2) == 0) begin
              // Stray response while the request is pending: must be ignored.
              mem_resp_valid = 1'b1;
              mem_resp_data  = $urandom;
            end
          end
          default: begin
            mem_req_ready = 1'b0;
            if (delay == 0) begin
              d              = use_fixed ? fix_data : $urandom;
              mem_resp_valid = 1'b1;
              mem_resp_data  = d;
              real_resp_fire = 1'b1;
              exp_resp_q.push_back(resp_t'{cur.lsu, cur.wen ? 32'h0 : d});
              mstate         = 0;
            end else begin
              delay--;
            end
          end
        endcase
      end
    end
  end

  // Response monitor.
  initial begin
    bit    last_real;
    resp_t r;
    last_real = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      if (ifu_resp_valid || lsu_resp_valid) begin
        if (exp_resp_q.size() == 0) begin
          chk("resp_unexpected", {ifu_resp_valid, lsu_resp_valid}, 2'b00);
        end else begin
          r = exp_resp_q.pop_front();
          chk("resp_latency", last_real, 1'b1);
          chk("resp_owner", {ifu_resp_valid, lsu_resp_valid}, {~r.lsu, r.lsu});
          chk("resp_data", r.lsu ? lsu_resp_data : ifu_resp_data, r.data);
        end
        txn_open = 1'b0;
      end
      last_real = real_resp_fire;
    end
  end

  initial begin
    bit exp_order[4];
    exp_order[0] = 1'b1; exp_order[1] = 1'b0; exp_order[2] = 1'b1; exp_order[3] = 1'b0;
    rst = 1'b0;
    ifu_req_valid = 1'b0; ifu_req_addr = 32'h0;
    lsu_req_valid = 1'b0; lsu_req_addr = 32'h0; lsu_req_wen = 1'b0;
    lsu_req_wdata = 32'h0; lsu_req_wmask = 4'h0;
    ifu_pend = 1'b0; lsu_pend = 1'b0; txn_open = 1'b0; last_lsu = 1'b0;
    use_fixed = 1'b0; fix_stall = 0; fix_delay = 0; fix_data = 32'h0;

    // Reset held with both requesters asking.
    ifu_req_valid = 1'b1;
    lsu_req_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      #2;
      chk("reset_outs", {ifu_req_ready, lsu_req_ready, ifu_resp_valid, lsu_resp_valid,
                         mem_req_valid, busy}, 6'b0);
      chk("reset_mem_addr", mem_req_addr, 32'h0);
    end
    @(posedge clk);
    #1;
    rst = 1'b1;

    // Continuous contention: first grant to LSU, then alternating.
    grant_log.delete();
    raise_ifu(32'h8000_0100);
    raise_lsu(32'h8000_0200, 1'b0, 32'h0, 4'hF);
    for (int k = 0; k < 200 && grant_log.size() < 4; k++) begin
      step();
      if (grant_log.size() < 4) begin
        if (!ifu_pend) raise_ifu(32'h8000_0100 + 32'(k * 4));
        if (!lsu_pend) raise_lsu(32'h8000_0200 + 32'(k * 4), k[0], 32'(k), 4'h3);
      end
    end
    drain();
    for (int i = 0; i < 4; i++)
      chk("grant_order", (grant_log.size() > i) ? {1'b0, grant_log[i]} : 2'b10,
          {1'b0, exp_order[i]});

    // IFU fetch with a fixed instruction word.
    use_fixed = 1'b1; fix_stall = 0; fix_delay = 1; fix_data = 32'h0000_0413;
    raise_ifu(32'h8000_0000);
    drain();

    // Store held against a 3-cycle memory stall.
    fix_stall = 3; fix_delay = 0; fix_data = 32'h1234_5678;
    raise_lsu(32'h8000_1000, 1'b1, 32'hDEAD_BEEF, 4'hF);
    drain();

    // Reset while waiting for the memory response.
    fix_stall = 0; fix_delay = 4;
    raise_ifu(32'h8000_0008);
    for (int k = 0; k < 20 && ifu_pend; k++) step();
    step();
    chk("in_resp_busy", busy, 1'b1);
    rst = 1'b0;
    @(negedge clk);
    #2;
    chk("mid_reset_outs", {busy, mem_req_valid, ifu_req_ready, lsu_req_ready}, 4'b0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    exp_req_q.delete();
    exp_resp_q.delete();
    txn_open = 1'b0;
    last_lsu = 1'b0;
    fix_delay = 0;
    repeat (4) step();
    raise_ifu(32'h8000_0004);
    drain();

    // Idle with stray memory responses, then random traffic.
    use_fixed = 1'b0;
    repeat (12) step();
    for (int i = 0; i < 400; i++) begin
      if (!ifu_pend && $urandom_range(0, 3) == 0) raise_ifu($urandom);
      if (!lsu_pend && $urandom_range(0, 3) == 0)
        raise_lsu($urandom, 1'($urandom_range(0, 1)), $urandom, 4'($urandom));
      step();
    end
    drain();
    repeat (3) step();
    chk("req_queue_empty", 64'(exp_req_q.size()), 64'h0);
    chk("resp_queue_empty", 64'(exp_resp_q.size()), 64'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
